ram_access_ctrl: RTL
====================

Name: ram_access_ctrl

Overview:
- Initiator side of the word-wide data RAM interface.
- Accepts byte-addressed load/store requests from the multicycle datapath over a valid/ready handshake and drives the RAM's write, word address and write-data inputs.
- Sub-word stores are performed as read-modify-write, because the RAM has no byte enables.
- Loads return a sign- or zero-extended result on a response handshake; misaligned accesses are rejected with an error response and never touch the RAM.

Parameters:
WIDTH, 32, RAM data width in bits; fixed at 32 (byte-lane logic assumes four bytes).
ADDR_WIDTH, 10, RAM word-address width; byte address space is 2^(ADDR_WIDTH+2).

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  load extension: 1 sign-extend, 0 zero-extend
req_addr  in  32  byte address
req_wdata  in  WIDTH  store data, right-justified
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  WIDTH  load result (0 for stores and errors)
rsp_err  out  1  request rejected
ram_write  out  1  RAM write strobe (RAM writes on rising edge when high)
ram_addr  out  ADDR_WIDTH  RAM word address
ram_inData  out  WIDTH  RAM write data
ram_outData  in  WIDTH  RAM read data (combinational from ram_addr)

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_write=0, ram_addr=0, ram_inData=0.
  - Request latches cleared.
  - Reset mid-operation abandons the access. A pending RMW write is never issued. A response not yet consumed is dropped.
- States: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE:
  - req_ready=1. Handshake occurs on an edge with req_valid&&req_ready. Latch write, size, signed, addr, wdata.
  - Error check: size=11, halfword with addr[0]=1, or word with addr[1:0]!=0 sets err. Next state is RESP, and the RAM is not accessed.
  - Otherwise next state is ACCESS. ram_addr <= req_addr[ADDR_WIDTH+1:2]. Address bits above ADDR_WIDTH+1 are ignored (wrap-around) unless the optional feature is enabled.
- ACCESS (req_ready=0):
  - Load: extract the lane from ram_outData and capture extended data into rsp_rdata. Next state RESP.
  - Word store: ram_write=1, ram_inData=wdata this cycle. Next state RESP.
  - Sub-word store: ram_write=0. Capture ram_outData with the target lane(s) replaced by wdata[7:0] or wdata[15:0] into ram_inData register. Next state MERGE_WR.
- MERGE_WR: ram_write=1 for exactly one cycle. Next state RESP.
- RESP:
  - rsp_valid=1, holding rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready.
  - On that edge go to IDLE; rsp_valid, rsp_err and rsp_rdata return to 0.
  - req_ready=0 throughout RESP. There is one outstanding request at most.
- Lane mapping (little-endian):
  - Byte lane n = bits [8n+7:8n], n = addr[1:0].
  - Halfword lane = addr[1] (bits [15:0] or [31:16]).
- Extension: signed loads replicate the lane MSB; unsigned loads zero-fill. Word loads ignore req_signed.
- Latency (handshake edge = cycle 0):
  - Load or word store: rsp_valid in cycle 2.
  - Sub-word store: rsp_valid in cycle 3.
  - Error: rsp_valid in cycle 1.
- ram_write is high only in ACCESS (word store) or MERGE_WR. It is never asserted for loads or errors.
- ram_addr holds its value after an access until the next accepted request.
- req_* inputs are don't-care outside the IDLE handshake edge. Changing them mid-operation has no effect.

Optional Feature:
- Macro RAM_ACCESS_BOUNDS_CHECK_EN.
- When defined: any req_addr with bits [31:ADDR_WIDTH+2] nonzero is treated as an error. It follows the same path as a misaligned request (RESP in cycle 1, rsp_err=1, no RAM access).
- When undefined: upper address bits are ignored and accesses alias modulo 2^(ADDR_WIDTH+2) bytes.

Test Plan:
- Word store 0xDEADBEEF to addr 0x48, then word load addr 0x48 -> ram_write one cycle with ram_addr=0x012, ram_inData=0xDEADBEEF; load rsp_valid at cycle 2 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte store 0x5A to addr 0x49 over word 0xDEADBEEF -> ram_write only in MERGE_WR with ram_inData=0xDEAD5AEF; rsp_valid at cycle 3.
- Loads from word 0xDEAD5AEF at 0x48: signed byte at 0x4B -> 0xFFFFFFDE; unsigned byte -> 0x000000DE; signed half at 0x48 -> 0x00005AEF; signed half at 0x4A -> 0xFFFFDEAD.
- Misaligned word load at 0x4A, halfword store at 0x49, and size=11 -> rsp_err=1, rsp_rdata=0, rsp_valid at cycle 1, ram_write never high.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_rdata stable, req_ready=0; new req_valid ignored until the response is consumed.
- Assert reset_n=0 during MERGE_WR of a byte store -> RAM word unchanged, all outputs at reset values immediately; with RAM_ACCESS_BOUNDS_CHECK_EN, a load at 0x00001000 (ADDR_WIDTH=10) -> rsp_err=1.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ============================================================================
// Module      : ram_access_ctrl
// Description : Load/store initiator for a word-wide RAM without byte enables.
//               Sub-word stores use read-modify-write; loads are extended.
//               Optional macro RAM_ACCESS_BOUNDS_CHECK_EN rejects addresses
//               beyond the RAM instead of letting them alias.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_access_ctrl #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_inData,
    input  logic [WIDTH-1:0]      ram_outData
);

    localparam logic [1:0] C_SIZE_BYTE = 2'b00;
    localparam logic [1:0] C_SIZE_HALF = 2'b01;
    localparam logic [1:0] C_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_MERGE_WR = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [1:0]            r_lane;
    logic [15:0]           r_wdata_lo;
    logic                  r_err;
    logic [WIDTH-1:0]      r_rdata;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [WIDTH-1:0]      r_ram_indata;

    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_oob;
    logic                  w_req_err;
    logic                  w_subword_store;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [WIDTH-1:0]      w_load_data;
    logic [WIDTH-1:0]      w_merged;

    assign w_accept        = req_valid && (r_state == S_IDLE);
    assign w_subword_store = r_write && (r_size != C_SIZE_WORD);

    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            C_SIZE_BYTE: w_misaligned = 1'b0;
            C_SIZE_HALF: w_misaligned = req_addr[0];
            C_SIZE_WORD: w_misaligned = |req_addr[1:0];
            default:     w_misaligned = 1'b1;
        endcase
    end

`ifdef RAM_ACCESS_BOUNDS_CHECK_EN
    assign w_oob = |req_addr[31:ADDR_WIDTH+2];
`else
    // Upper address bits are intentionally dropped so accesses alias.
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, req_addr[31:ADDR_WIDTH+2]};
    assign w_oob         = 1'b0;
`endif

    assign w_req_err = w_misaligned | w_oob;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_req_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS:   w_state_next = w_subword_store ? S_MERGE_WR : S_RESP;
            S_MERGE_WR: w_state_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Little-endian lane extraction and load extension.
    always_comb begin
        w_byte      = ram_outData[{r_lane, 3'b000} +: 8];
        w_half      = ram_outData[{r_lane[1], 4'b0000} +: 16];
        w_load_data = ram_outData;
        case (r_size)
            C_SIZE_BYTE: w_load_data = {{(WIDTH-8){r_signed & w_byte[7]}}, w_byte};
            C_SIZE_HALF: w_load_data = {{(WIDTH-16){r_signed & w_half[15]}}, w_half};
            default:     w_load_data = ram_outData;
        endcase
    end

    always_comb begin
        w_merged = ram_outData;
        if (r_size == C_SIZE_BYTE) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata_lo[7:0];
        end else begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata_lo;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_lane       <= 2'b00;
            r_wdata_lo   <= '0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_ram_addr   <= '0;
            r_ram_indata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_signed   <= req_signed;
                        r_lane     <= req_addr[1:0];
                        r_wdata_lo <= req_wdata[15:0];
                        r_err      <= w_req_err;
                        r_rdata    <= '0;
                        if (!w_req_err) begin
                            r_ram_addr <= req_addr[ADDR_WIDTH+1:2];
                            // Word stores write straight from ACCESS, so stage the data now.
                            if (req_write && (req_size == C_SIZE_WORD)) begin
                                r_ram_indata <= req_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_write) begin
                        r_rdata <= w_load_data;
                    end else if (w_subword_store) begin
                        r_ram_indata <= w_merged;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_err   <= 1'b0;
                        r_rdata <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_err    = r_err;
    assign rsp_rdata  = r_rdata;
    assign ram_write  = ((r_state == S_ACCESS) && r_write && (r_size == C_SIZE_WORD))
                      || (r_state == S_MERGE_WR);
    assign ram_addr   = r_ram_addr;
    assign ram_inData = r_ram_indata;

endmodule

`default_nettype wire
